// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and EX-stage data requests.
// One outstanding transaction; data has priority unless fetch has starved STARVE_LIMIT grants.
module mem_port_arbiter #(
    parameter int unsigned                ADDR_W         = 32,
    parameter int unsigned                WORD_W         = 32,
    parameter int unsigned                MEM_COUNT_W    = 2,
    parameter logic [MEM_COUNT_W-1:0]     MEM_COUNT_NONE = '0,
    parameter logic [MEM_COUNT_W-1:0]     MEM_COUNT_WORD = '1,
    parameter int unsigned                STARVE_LIMIT   = 4,
    parameter int unsigned                STARVE_W       = 3
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   i_if_req,
    input  logic [ADDR_W-1:0]      i_if_addr,
    input  logic [ADDR_W-1:0]      i_d_addr,
    input  logic [WORD_W-1:0]      i_d_wr_data,
    input  logic                   i_d_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_d_count,
    output logic                   o_if_stall,
    output logic                   o_if_rsp_valid,
    output logic [WORD_W-1:0]      o_if_rd_data,
    output logic                   o_d_stall,
    output logic                   o_d_rsp_valid,
    output logic [WORD_W-1:0]      o_d_rd_data,
    output logic                   o_mem_valid,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [WORD_W-1:0]      o_mem_wr_data,
    output logic                   o_mem_wr_en,
    output logic [MEM_COUNT_W-1:0] o_mem_count,
    input  logic                   i_mem_ready,
    input  logic                   i_mem_rsp_valid,
    input  logic [WORD_W-1:0]      i_mem_rd_data
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);

    state_e                 state_q;
    owner_e                 owner_q;
    logic [STARVE_W-1:0]    starve_q;
    logic                   mem_valid_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [WORD_W-1:0]      mem_wr_data_q;
    logic                   mem_wr_en_q;
    logic [MEM_COUNT_W-1:0] mem_count_q;
    logic                   if_rsp_valid_q;
    logic [WORD_W-1:0]      if_rd_data_q;
    logic                   d_rsp_valid_q;
    logic [WORD_W-1:0]      d_rd_data_q;

    logic                   d_req;
    logic                   if_live;
    logic                   d_live;
    logic                   any_live;
    logic                   fetch_wins;
    logic                   do_grant;
    owner_e                 g_owner;
    logic [ADDR_W-1:0]      g_addr;
    logic [WORD_W-1:0]      g_wr_data;
    logic                   g_wr_en;
    logic [MEM_COUNT_W-1:0] g_count;

    assign d_req = (i_d_count != MEM_COUNT_NONE);

    // A requester being handed its response this cycle is still showing the old request.
    assign if_live    = i_if_req & ~if_rsp_valid_q;
    assign d_live     = d_req & ~d_rsp_valid_q;
    assign any_live   = if_live | d_live;
    assign fetch_wins = if_live & (~d_live | (starve_q == StarveMax));
    assign do_grant   = any_live &
                        ((state_q == StIdle) | ((state_q == StWait) & i_mem_rsp_valid));

    always_comb begin
        g_owner   = OwnNone;
        g_addr    = '0;
        g_wr_data = '0;
        g_wr_en   = 1'b0;
        g_count   = MEM_COUNT_NONE;
        if (fetch_wins) begin
            g_owner = OwnFetch;
            g_addr  = i_if_addr;
            g_count = MEM_COUNT_WORD;
        end else if (d_live) begin
            g_owner   = OwnData;
            g_addr    = i_d_addr;
            g_wr_data = i_d_wr_data;
            g_wr_en   = i_d_wr_en;
            g_count   = i_d_count;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= StIdle;
            owner_q        <= OwnNone;
            starve_q       <= '0;
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_count_q    <= MEM_COUNT_NONE;
            if_rsp_valid_q <= 1'b0;
            if_rd_data_q   <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rd_data_q    <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;

            case (state_q)
                StReq: begin
                    if (i_mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (i_mem_rsp_valid) begin
                        if (owner_q == OwnFetch) begin
                            if_rsp_valid_q <= 1'b1;
                            if_rd_data_q   <= i_mem_rd_data;
                        end else if (owner_q == OwnData) begin
                            d_rsp_valid_q <= 1'b1;
                            // A write ack carries no load data.
                            if (!mem_wr_en_q) begin
                                d_rd_data_q <= i_mem_rd_data;
                            end
                        end
                        state_q <= StIdle;
                        owner_q <= OwnNone;
                    end
                end
                default: ;
            endcase

            // Grant overrides the completion transition above when a request is waiting.
            if (do_grant) begin
                state_q       <= StReq;
                owner_q       <= g_owner;
                mem_valid_q   <= 1'b1;
                mem_addr_q    <= g_addr;
                mem_wr_data_q <= g_wr_data;
                mem_wr_en_q   <= g_wr_en;
                mem_count_q   <= g_count;
                if (fetch_wins) begin
                    starve_q <= '0;
                end else if (i_if_req && (starve_q != StarveMax)) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
        end
    end

    assign o_if_stall     = i_if_req & ~if_rsp_valid_q;
    assign o_d_stall      = d_req & ~d_rsp_valid_q;
    assign o_if_rsp_valid = if_rsp_valid_q;
    assign o_if_rd_data   = if_rd_data_q;
    assign o_d_rsp_valid  = d_rsp_valid_q;
    assign o_d_rd_data    = d_rd_data_q;
    assign o_mem_valid    = mem_valid_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wr_data  = mem_wr_data_q;
    assign o_mem_wr_en    = mem_wr_en_q;
    assign o_mem_count    = mem_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus
// hand-written sequences for arbitration, starvation, backpressure and reset corners.
module tb_mem_port_arbiter;

    localparam logic [1:0] CNT_NONE = 2'd0;
    localparam logic [1:0] CNT_BYTE = 2'd1;
    localparam logic [1:0] CNT_HALF = 2'd2;
    localparam logic [1:0] CNT_WORD = 2'd3;

    logic        clk;
    logic        clr_n;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wr_data;
    logic        i_d_wr_en;
    logic [1:0]  i_d_count;
    logic        o_if_stall;
    logic        o_if_rsp_valid;
    logic [31:0] o_if_rd_data;
    logic        o_d_stall;
    logic        o_d_rsp_valid;
    logic [31:0] o_d_rd_data;
    logic        o_mem_valid;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wr_data;
    logic        o_mem_wr_en;
    logic [1:0]  o_mem_count;
    logic        i_mem_ready;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rd_data;

    int total;
    int bad;

    mem_port_arbiter dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .i_if_req       (i_if_req),
        .i_if_addr      (i_if_addr),
        .i_d_addr       (i_d_addr),
        .i_d_wr_data    (i_d_wr_data),
        .i_d_wr_en      (i_d_wr_en),
        .i_d_count      (i_d_count),
        .o_if_stall     (o_if_stall),
        .o_if_rsp_valid (o_if_rsp_valid),
        .o_if_rd_data   (o_if_rd_data),
        .o_d_stall      (o_d_stall),
        .o_d_rsp_valid  (o_d_rsp_valid),
        .o_d_rd_data    (o_d_rd_data),
        .o_mem_valid    (o_mem_valid),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wr_data  (o_mem_wr_data),
        .o_mem_wr_en    (o_mem_wr_en),
        .o_mem_count    (o_mem_count),
        .i_mem_ready    (i_mem_ready),
        .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rd_data  (i_mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_fetch;
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic        wr_en;
        logic [1:0]  count;
        logic [31:0] mem_rd;
        logic        exp_wr_en;
        logic [1:0]  exp_count;
        logic [31:0] exp_if_rd;
        logic [31:0] exp_d_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_if_req        = 1'b0;
        i_if_addr       = '0;
        i_d_addr        = '0;
        i_d_wr_data     = '0;
        i_d_wr_en       = 1'b0;
        i_d_count       = CNT_NONE;
        i_mem_ready     = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rd_data   = '0;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_n = 1'b0;
        idle_inputs();

        //          fetch addr      wr_data       we   count     mem_rd        ewe  ecount    if_rd         d_rd
        vecs[0] = '{1'b1, 32'h104, 32'h0,        1'b0, CNT_WORD, 32'h11112222, 1'b0, CNT_WORD, 32'h11112222, 32'h0};
        vecs[1] = '{1'b0, 32'h080, 32'h0,        1'b0, CNT_WORD, 32'h33334444, 1'b0, CNT_WORD, 32'h11112222, 32'h33334444};
        vecs[2] = '{1'b0, 32'h084, 32'hAABBCCDD, 1'b1, CNT_WORD, 32'hFFFFFFFF, 1'b1, CNT_WORD, 32'h11112222, 32'h33334444};
        vecs[3] = '{1'b0, 32'h085, 32'h0,        1'b0, CNT_BYTE, 32'h000000DD, 1'b0, CNT_BYTE, 32'h11112222, 32'h000000DD};
        vecs[4] = '{1'b0, 32'h086, 32'h0000BEEF, 1'b1, CNT_HALF, 32'h12121212, 1'b1, CNT_HALF, 32'h11112222, 32'h000000DD};
        vecs[5] = '{1'b1, 32'h108, 32'h0,        1'b0, CNT_WORD, 32'h55556666, 1'b0, CNT_WORD, 32'h55556666, 32'h000000DD};
        vecs[6] = '{1'b0, 32'h08A, 32'h0,        1'b0, CNT_HALF, 32'h0000ABCD, 1'b0, CNT_HALF, 32'h55556666, 32'h0000ABCD};

        // Reset state
        do_reset();
        chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wr_data", o_mem_wr_data, 32'h0);
        chk("rst_mem_wr_en", 32'(o_mem_wr_en), 32'd0);
        chk("rst_mem_count", 32'(o_mem_count), 32'(CNT_NONE));
        chk("rst_if_rsp", 32'(o_if_rsp_valid), 32'd0);
        chk("rst_d_rsp", 32'(o_d_rsp_valid), 32'd0);
        chk("rst_if_rd", o_if_rd_data, 32'h0);
        chk("rst_d_rd", o_d_rd_data, 32'h0);

        // Table: one isolated transaction per row, requester drops on the response cycle
        for (int i = 0; i < 7; i++) begin
            i_mem_ready = 1'b1;
            if (vecs[i].is_fetch) begin
                i_if_req  = 1'b1;
                i_if_addr = vecs[i].addr;
            end else begin
                i_d_addr    = vecs[i].addr;
                i_d_wr_data = vecs[i].wr_data;
                i_d_wr_en   = vecs[i].wr_en;
                i_d_count   = vecs[i].count;
            end
            #1;
            chk($sformatf("v%0d_c0_valid", i), 32'(o_mem_valid), 32'd0);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(o_mem_valid), 32'd1);
            chk($sformatf("v%0d_addr", i), o_mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_wr_en", i), 32'(o_mem_wr_en), 32'(vecs[i].exp_wr_en));
            chk($sformatf("v%0d_count", i), 32'(o_mem_count), 32'(vecs[i].exp_count));
            if (vecs[i].wr_en && !vecs[i].is_fetch)
                chk($sformatf("v%0d_wr_data", i), o_mem_wr_data, vecs[i].wr_data);
            chk($sformatf("v%0d_stall", i),
                32'(vecs[i].is_fetch ? o_if_stall : o_d_stall), 32'd1);
            tick();
            chk($sformatf("v%0d_accepted", i), 32'(o_mem_valid), 32'd0);
            i_mem_rsp_valid = 1'b1;
            i_mem_rd_data   = vecs[i].mem_rd;
            i_if_req        = 1'b0;
            i_d_count       = CNT_NONE;
            tick();
            i_mem_rsp_valid = 1'b0;
            i_mem_ready     = 1'b0;
            #1;
            chk($sformatf("v%0d_if_rsp", i), 32'(o_if_rsp_valid), 32'(vecs[i].is_fetch));
            chk($sformatf("v%0d_d_rsp", i), 32'(o_d_rsp_valid), 32'(!vecs[i].is_fetch));
            chk($sformatf("v%0d_if_rd", i), o_if_rd_data, vecs[i].exp_if_rd);
            chk($sformatf("v%0d_d_rd", i), o_d_rd_data, vecs[i].exp_d_rd);
            tick();
            chk($sformatf("v%0d_idle", i), 32'(o_mem_valid | o_if_rsp_valid | o_d_rsp_valid), 32'd0);
        end

        // Spurious memory response while idle
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'h5A5A5A5A;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("spur_if_rsp", 32'(o_if_rsp_valid), 32'd0);
        chk("spur_d_rsp", 32'(o_d_rsp_valid), 32'd0);
        chk("spur_if_rd", o_if_rd_data, 32'h55556666);
        chk("spur_d_rd", o_d_rd_data, 32'h0000ABCD);
        chk("spur_valid", 32'(o_mem_valid), 32'd0);

        // Fetch-only minimum latency
        do_reset();
        i_if_req    = 1'b1;
        i_if_addr   = 32'h100;
        i_mem_ready = 1'b1;
        #1;
        chk("f_stall_c0", 32'(o_if_stall), 32'd1);
        chk("f_valid_c0", 32'(o_mem_valid), 32'd0);
        tick();
        chk("f_valid_c1", 32'(o_mem_valid), 32'd1);
        chk("f_addr_c1", o_mem_addr, 32'h100);
        chk("f_count_c1", 32'(o_mem_count), 32'(CNT_WORD));
        chk("f_stall_c1", 32'(o_if_stall), 32'd1);
        tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'hDEADBEEF;
        #1;
        chk("f_stall_c2", 32'(o_if_stall), 32'd1);
        chk("f_rsp_c2", 32'(o_if_rsp_valid), 32'd0);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_if_req        = 1'b0;
        i_if_req        = 1'b1;
        #1;
        chk("f_rsp_c3", 32'(o_if_rsp_valid), 32'd1);
        chk("f_rd_c3", o_if_rd_data, 32'hDEADBEEF);
        chk("f_stall_c3", 32'(o_if_stall), 32'd0);

        // Simultaneous store and fetch: store first, fetch right after the ack
        do_reset();
        i_if_req    = 1'b1;
        i_if_addr   = 32'h200;
        i_d_addr    = 32'h40;
        i_d_wr_data = 32'h12345678;
        i_d_wr_en   = 1'b1;
        i_d_count   = CNT_WORD;
        i_mem_ready = 1'b1;
        tick();
        chk("s_addr", o_mem_addr, 32'h40);
        chk("s_wr_en", 32'(o_mem_wr_en), 32'd1);
        chk("s_wr_data", o_mem_wr_data, 32'h12345678);
        chk("s_if_stall", 32'(o_if_stall), 32'd1);
        tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'h0BADF00D;
        i_d_count       = CNT_NONE;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("s_d_rsp", 32'(o_d_rsp_valid), 32'd1);
        chk("s_d_rd_kept", o_d_rd_data, 32'h0);
        chk("s_f_valid", 32'(o_mem_valid), 32'd1);
        chk("s_f_addr", o_mem_addr, 32'h200);
        chk("s_f_wr_en", 32'(o_mem_wr_en), 32'd0);
        chk("s_f_stall", 32'(o_if_stall), 32'd1);
        tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'hCAFEF00D;
        i_if_req        = 1'b0;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("s_f_rsp", 32'(o_if_rsp_valid), 32'd1);
        chk("s_f_rd", o_if_rd_data, 32'hCAFEF00D);
        chk("s_idle", 32'(o_mem_valid), 32'd0);

        // Starvation: fetch waits behind four data grants, then wins
        do_reset();
        i_if_req    = 1'b1;
        i_if_addr   = 32'h300;
        i_d_addr    = 32'h10;
        i_d_count   = CNT_BYTE;
        i_mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("st_addr%0d", k), o_mem_addr, 32'h10 + 32'(k));
            chk($sformatf("st_count%0d", k), 32'(o_mem_count), 32'(CNT_BYTE));
            chk($sformatf("st_stall%0d", k), 32'(o_if_stall), 32'd1);
            if (k > 0) chk($sformatf("st_drd%0d", k), o_d_rd_data, 32'hA0 + 32'(k - 1));
            tick();
            i_mem_rsp_valid = 1'b1;
            i_mem_rd_data   = 32'hA0 + 32'(k);
            i_d_addr        = 32'h10 + 32'(k + 1);
            tick();
            i_mem_rsp_valid = 1'b0;
        end
        #1;
        chk("st_fetch_addr", o_mem_addr, 32'h300);
        chk("st_fetch_count", 32'(o_mem_count), 32'(CNT_WORD));
        chk("st_d_rsp4", 32'(o_d_rsp_valid), 32'd1);
        chk("st_d_rd4", o_d_rd_data, 32'hA3);
        tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'hF00DF00D;
        tick();
        i_mem_rsp_valid = 1'b0;
        i_if_req        = 1'b0;
        #1;
        chk("st_if_rsp", 32'(o_if_rsp_valid), 32'd1);
        chk("st_if_rd", o_if_rd_data, 32'hF00DF00D);
        chk("st_load5_addr", o_mem_addr, 32'h14);
        chk("st_load5_valid", 32'(o_mem_valid), 32'd1);
        tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'hA4;
        i_d_count       = CNT_NONE;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("st_d_rsp5", 32'(o_d_rsp_valid), 32'd1);
        chk("st_d_rd5", o_d_rd_data, 32'hA4);
        chk("st_idle", 32'(o_mem_valid), 32'd0);

        // Backpressure: ready low for three REQ cycles
        do_reset();
        i_d_addr  = 32'h62;
        i_d_count = CNT_HALF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_valid%0d", k), 32'(o_mem_valid), 32'd1);
            chk($sformatf("bp_addr%0d", k), o_mem_addr, 32'h62);
            chk($sformatf("bp_count%0d", k), 32'(o_mem_count), 32'(CNT_HALF));
        end
        tick();
        i_mem_ready = 1'b1;
        chk("bp_valid_hold", 32'(o_mem_valid), 32'd1);
        tick();
        i_mem_ready = 1'b0;
        chk("bp_valid_drop", 32'(o_mem_valid), 32'd0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'h7777;
        i_d_count       = CNT_NONE;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("bp_d_rsp", 32'(o_d_rsp_valid), 32'd1);
        chk("bp_d_rd", o_d_rd_data, 32'h7777);
        tick();
        chk("bp_single", 32'(o_mem_valid | o_d_rsp_valid), 32'd0);

        // Reset while waiting for a response; the late response is dropped
        do_reset();
        i_if_req    = 1'b1;
        i_if_addr   = 32'h400;
        i_mem_ready = 1'b1;
        tick();
        tick();
        clr_n    = 1'b0;
        i_if_req = 1'b0;
        #1;
        chk("ar_valid", 32'(o_mem_valid), 32'd0);
        chk("ar_addr", o_mem_addr, 32'h0);
        chk("ar_count", 32'(o_mem_count), 32'(CNT_NONE));
        chk("ar_stall", 32'(o_if_stall), 32'd0);
        tick();
        clr_n           = 1'b1;
        i_mem_rsp_valid = 1'b1;
        i_mem_rd_data   = 32'h99;
        tick();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("ar_if_rsp", 32'(o_if_rsp_valid), 32'd0);
        chk("ar_d_rsp", 32'(o_d_rsp_valid), 32'd0);
        chk("ar_if_rd", o_if_rd_data, 32'h0);
        chk("ar_valid2", 32'(o_mem_valid), 32'd0);
        tick();
        chk("ar_idle", 32'(o_mem_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
